// File: rtl/spi_slave_frame.sv
// SPI frame receiver: oversamples sck/cs/mosi in the clk domain, emits one rdy per word.
// Optional MISO transmitter is enabled by defining SPI_SLAVE_MISO_EN.
module spi_slave_frame #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SPI_MODE   = 1,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  cs,
  input  logic                  mosi,
`ifdef SPI_SLAVE_MISO_EN
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  miso,
`endif
  output logic                  rdy,
  output logic [DATA_WIDTH-1:0] data,
  output logic [IDX_W-1:0]      idx,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  err,
  output logic                  busy
);

  localparam bit CPOL        = ((SPI_MODE / 2) % 2) == 1;
  localparam bit CPHA        = (SPI_MODE % 2) == 1;
  localparam bit SAMPLE_RISE = (CPOL == CPHA);
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {StIdle, StActive} state_t;

  logic r_sck_meta, r_sck_sync, r_sck_hist;
  logic r_cs_meta, r_cs_sync, r_cs_hist;
  logic r_mosi_meta, r_mosi_sync;
  logic [1:0] r_settle;
  logic r_armed;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_bitcnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_rdy, r_fs, r_fe, r_err, r_busy;

  logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
  logic w_active, w_sample, w_shift_edge;
  logic [DATA_WIDTH-1:0] w_shift_next;

  // r_armed blocks a frame until cs has been seen high after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sck_meta  <= CPOL;
      r_sck_sync  <= CPOL;
      r_sck_hist  <= CPOL;
      r_cs_meta   <= 1'b1;
      r_cs_sync   <= 1'b1;
      r_cs_hist   <= 1'b1;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
      r_settle    <= 2'd0;
      r_armed     <= 1'b0;
    end else begin
      r_sck_meta  <= sck;
      r_sck_sync  <= r_sck_meta;
      r_sck_hist  <= r_sck_sync;
      r_cs_meta   <= cs;
      r_cs_sync   <= r_cs_meta;
      r_cs_hist   <= r_cs_sync;
      r_mosi_meta <= mosi;
      r_mosi_sync <= r_mosi_meta;
      if (r_settle != 2'd2) begin
        r_settle <= r_settle + 2'd1;
      end else if (r_cs_sync) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_sck_rise   = r_sck_sync & ~r_sck_hist;
  assign w_sck_fall   = ~r_sck_sync & r_sck_hist;
  assign w_cs_fall    = r_cs_hist & ~r_cs_sync & r_armed;
  assign w_cs_rise    = r_cs_sync & ~r_cs_hist;
  assign w_active     = (r_state == StActive) & ~r_cs_sync;
  assign w_sample     = w_active & (SAMPLE_RISE ? w_sck_rise : w_sck_fall);
  assign w_shift_edge = w_active & (SAMPLE_RISE ? w_sck_fall : w_sck_rise);

  always_comb begin
    w_shift_next = r_shift;
    if (MSB_FIRST) begin
      w_shift_next = {r_shift[DATA_WIDTH-2:0], r_mosi_sync};
    end else begin
      w_shift_next = {r_mosi_sync, r_shift[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_data   <= '0;
      r_idx    <= '0;
      r_rdy    <= 1'b0;
      r_fs     <= 1'b0;
      r_fe     <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      r_fs  <= 1'b0;
      r_fe  <= 1'b0;
      // idx holds the completed word's index during rdy, then advances.
      if (r_rdy) r_idx <= r_idx + 1'b1;
      case (r_state)
        StIdle: begin
          if (w_cs_fall) begin
            r_state  <= StActive;
            r_fs     <= 1'b1;
            r_busy   <= 1'b1;
            r_idx    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_err    <= 1'b0;
          end
        end
        StActive: begin
          if (w_cs_rise) begin
            r_state  <= StIdle;
            r_fe     <= 1'b1;
            r_busy   <= 1'b0;
            r_err    <= (r_bitcnt != '0);
            r_bitcnt <= '0;
          end else if (w_sample) begin
            r_shift <= w_shift_next;
            if (r_bitcnt == LAST_BIT) begin
              r_bitcnt <= '0;
              r_data   <= w_shift_next;
              r_rdy    <= 1'b1;
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign rdy         = r_rdy;
  assign data        = r_data;
  assign idx         = r_idx;
  assign frame_start = r_fs;
  assign frame_end   = r_fe;
  assign err         = r_err;
  assign busy        = r_busy;

`ifdef SPI_SLAVE_MISO_EN
  logic [DATA_WIDTH-1:0] r_tx, w_tx_src;
  logic                  r_miso;

  function automatic logic tx_head(input logic [DATA_WIDTH-1:0] v);
    return MSB_FIRST ? v[DATA_WIDTH-1] : v[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] tx_adv(input logic [DATA_WIDTH-1:0] v);
    return MSB_FIRST ? {v[DATA_WIDTH-2:0], 1'b0} : {1'b0, v[DATA_WIDTH-1:1]};
  endfunction

  // A shift edge landing on the reload cycle shifts the freshly loaded word.
  assign w_tx_src = r_rdy ? tx_data : r_tx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx   <= '0;
      r_miso <= 1'b0;
    end else if ((r_state == StIdle) && w_cs_fall) begin
      if (!CPHA) begin
        r_miso <= tx_head(tx_data);
        r_tx   <= tx_adv(tx_data);
      end else begin
        r_miso <= 1'b0;
        r_tx   <= tx_data;
      end
    end else if (w_active) begin
      if (w_shift_edge) begin
        r_miso <= tx_head(w_tx_src);
        r_tx   <= tx_adv(w_tx_src);
      end else if (r_rdy) begin
        r_tx <= tx_data;
      end
    end else begin
      r_miso <= 1'b0;
    end
  end

  assign miso = r_miso;
`endif

endmodule

// File: tb/tb_spi_slave_frame.sv
// Bench for spi_slave_frame: five instances (modes 0..3, 16-bit LSB-first) on shared SPI pins.
module tb_spi_slave_frame;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sck = 1'b0;
  logic cs = 1'b1;
  logic mosi = 1'b0;

  logic [4:0]      rdy_v, fs_v, fe_v, err_v, busy_v, miso_v;
  logic [3:0][7:0] dat8_v;
  logic [15:0]     d16;
  logic [4:0][3:0] idx_v;
  logic [7:0]      tx8 = 8'hA5;
  logic [15:0]     tx16 = 16'h0000;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

`ifndef SPI_SLAVE_MISO_EN
  assign miso_v = '0;
`endif

  spi_slave_frame #(.DATA_WIDTH(8), .SPI_MODE(0), .MSB_FIRST(1'b1), .IDX_W(4)) u_m0 (
    .clk(clk), .reset(reset), .sck(sck), .cs(cs), .mosi(mosi),
`ifdef SPI_SLAVE_MISO_EN
    .tx_data(tx8), .miso(miso_v[0]),
`endif
    .rdy(rdy_v[0]), .data(dat8_v[0]), .idx(idx_v[0]), .frame_start(fs_v[0]),
    .frame_end(fe_v[0]), .err(err_v[0]), .busy(busy_v[0])
  );

  spi_slave_frame #(.DATA_WIDTH(8), .SPI_MODE(1), .MSB_FIRST(1'b1), .IDX_W(4)) u_m1 (
    .clk(clk), .reset(reset), .sck(sck), .cs(cs), .mosi(mosi),
`ifdef SPI_SLAVE_MISO_EN
    .tx_data(tx8), .miso(miso_v[1]),
`endif
    .rdy(rdy_v[1]), .data(dat8_v[1]), .idx(idx_v[1]), .frame_start(fs_v[1]),
    .frame_end(fe_v[1]), .err(err_v[1]), .busy(busy_v[1])
  );

  spi_slave_frame #(.DATA_WIDTH(8), .SPI_MODE(2), .MSB_FIRST(1'b1), .IDX_W(4)) u_m2 (
    .clk(clk), .reset(reset), .sck(sck), .cs(cs), .mosi(mosi),
`ifdef SPI_SLAVE_MISO_EN
    .tx_data(tx8), .miso(miso_v[2]),
`endif
    .rdy(rdy_v[2]), .data(dat8_v[2]), .idx(idx_v[2]), .frame_start(fs_v[2]),
    .frame_end(fe_v[2]), .err(err_v[2]), .busy(busy_v[2])
  );

  spi_slave_frame #(.DATA_WIDTH(8), .SPI_MODE(3), .MSB_FIRST(1'b1), .IDX_W(4)) u_m3 (
    .clk(clk), .reset(reset), .sck(sck), .cs(cs), .mosi(mosi),
`ifdef SPI_SLAVE_MISO_EN
    .tx_data(tx8), .miso(miso_v[3]),
`endif
    .rdy(rdy_v[3]), .data(dat8_v[3]), .idx(idx_v[3]), .frame_start(fs_v[3]),
    .frame_end(fe_v[3]), .err(err_v[3]), .busy(busy_v[3])
  );

  spi_slave_frame #(.DATA_WIDTH(16), .SPI_MODE(1), .MSB_FIRST(1'b0), .IDX_W(4)) u_w16 (
    .clk(clk), .reset(reset), .sck(sck), .cs(cs), .mosi(mosi),
`ifdef SPI_SLAVE_MISO_EN
    .tx_data(tx16), .miso(miso_v[4]),
`endif
    .rdy(rdy_v[4]), .data(d16), .idx(idx_v[4]), .frame_start(fs_v[4]),
    .frame_end(fe_v[4]), .err(err_v[4]), .busy(busy_v[4])
  );

  // Monitors only accumulate; the test reads deltas around each transfer.
  int          rdy_cnt [5];
  logic [15:0] last_data [5];
  logic [3:0]  last_idx [5];
  int          fs_cnt = 0;
  int          fe_cnt = 0;
  logic [7:0]  q_data [$];
  logic [3:0]  q_idx [$];

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rdy_v[k]) begin
        rdy_cnt[k]++;
        last_data[k] = {8'h00, dat8_v[k]};
        last_idx[k]  = idx_v[k];
      end
    end
    if (rdy_v[4]) begin
      rdy_cnt[4]++;
      last_data[4] = d16;
      last_idx[4]  = idx_v[4];
    end
    if (rdy_v[1]) begin
      q_data.push_back(dat8_v[1]);
      q_idx.push_back(idx_v[1]);
    end
    if (fs_v[1]) fs_cnt++;
    if (fe_v[1]) fe_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  localparam int HALF = 4;

  // SPI master: sends nbits of tx MSB-first on the wire, captures miso on its sample edge.
  task automatic spi_xfer(input int mode, input logic [63:0] tx, input int nbits,
                          output logic [63:0] rx);
    logic cpol, cpha;
    cpol = (mode / 2) % 2 == 1;
    cpha = mode % 2 == 1;
    rx = '0;
    sck = cpol;
    clks(6);
    if (!cpha) mosi = tx[nbits-1];
    cs = 1'b0;
    clks(2 * HALF);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!cpha) begin
        rx = {rx[62:0], miso_v[1]};
        sck = ~cpol;
        clks(HALF);
        sck = cpol;
        mosi = (i > 0) ? tx[i-1] : 1'b0;
        clks(HALF);
      end else begin
        sck = ~cpol;
        mosi = tx[i];
        clks(HALF);
        rx = {rx[62:0], miso_v[1]};
        sck = cpol;
        clks(HALF);
      end
    end
    clks(2 * HALF);
    cs = 1'b1;
    mosi = 1'b0;
    clks(10);
  endtask

  typedef struct {
    int          mode;
    int          dut;
    logic [63:0] bits;
    int          nbits;
    logic [15:0] exp;
  } vec_t;

  initial begin
    vec_t        vecs [6];
    logic [63:0] rx;
    logic [7:0]  exp_words [4];
    int c0, s0, fs0, fe0;
    logic [7:0] qd;
    logic [3:0] qi;

    vecs[0] = '{mode: 0, dut: 0, bits: 64'hC3, nbits: 8, exp: 16'h00C3};
    vecs[1] = '{mode: 2, dut: 2, bits: 64'hC3, nbits: 8, exp: 16'h00C3};
    vecs[2] = '{mode: 3, dut: 3, bits: 64'hC3, nbits: 8, exp: 16'h00C3};
    vecs[3] = '{mode: 1, dut: 1, bits: 64'h5A, nbits: 8, exp: 16'h005A};
    // 0x2C48 is 0x1234 bit-reversed, so the wire carries 0x1234 LSB-first.
    vecs[4] = '{mode: 1, dut: 4, bits: 64'h2C48, nbits: 16, exp: 16'h1234};
    vecs[5] = '{mode: 1, dut: 1, bits: 64'h81, nbits: 8, exp: 16'h0081};
    exp_words[0] = 8'h55; exp_words[1] = 8'h00; exp_words[2] = 8'h23; exp_words[3] = 8'hA4;

    clks(3);
    reset = 1'b0;
    clks(6);
    check("reset_rdy", 32'(rdy_v[1]), 32'd0);
    check("reset_data", 32'(dat8_v[1]), 32'd0);
    check("reset_idx", 32'(idx_v[1]), 32'd0);
    check("reset_frame_start", 32'(fs_v[1]), 32'd0);
    check("reset_frame_end", 32'(fe_v[1]), 32'd0);
    check("reset_err", 32'(err_v[1]), 32'd0);
    check("reset_busy", 32'(busy_v[1]), 32'd0);
`ifdef SPI_SLAVE_MISO_EN
    check("reset_miso", 32'(miso_v[1]), 32'd0);
`endif

    // Four-word frame in mode 1.
    c0 = rdy_cnt[1]; s0 = q_data.size(); fs0 = fs_cnt; fe0 = fe_cnt;
    spi_xfer(1, 64'h5500_23A4, 32, rx);
    check("frame_rdy_count", 32'(rdy_cnt[1] - c0), 32'd4);
    for (int j = 0; j < 4; j++) begin
      qd = (s0 + j < q_data.size()) ? q_data[s0+j] : 8'hxx;
      qi = (s0 + j < q_idx.size()) ? q_idx[s0+j] : 4'hx;
      check($sformatf("frame_data%0d", j), 32'(qd), 32'(exp_words[j]));
      check($sformatf("frame_idx%0d", j), 32'(qi), 32'(j));
    end
    check("frame_start_count", 32'(fs_cnt - fs0), 32'd1);
    check("frame_end_count", 32'(fe_cnt - fe0), 32'd1);
    check("frame_err", 32'(err_v[1]), 32'd0);
    check("frame_busy_after", 32'(busy_v[1]), 32'd0);

    // Partial word sets err; the next frame start clears it.
    c0 = rdy_cnt[1]; fe0 = fe_cnt;
    spi_xfer(1, 64'b10110, 5, rx);
    check("partial_no_rdy", 32'(rdy_cnt[1] - c0), 32'd0);
    check("partial_err", 32'(err_v[1]), 32'd1);
    check("partial_frame_end", 32'(fe_cnt - fe0), 32'd1);
    cs = 1'b0;
    clks(8);
    check("partial_err_cleared", 32'(err_v[1]), 32'd0);
    check("partial_busy", 32'(busy_v[1]), 32'd1);
    cs = 1'b1;
    clks(8);

    for (int v = 0; v < 6; v++) begin
      c0 = rdy_cnt[vecs[v].dut];
      spi_xfer(vecs[v].mode, vecs[v].bits, vecs[v].nbits, rx);
      check($sformatf("vec%0d_rdy", v), 32'(rdy_cnt[vecs[v].dut] - c0), 32'd1);
      check($sformatf("vec%0d_data", v), 32'(last_data[vecs[v].dut]), 32'(vecs[v].exp));
      check($sformatf("vec%0d_idx", v), 32'(last_idx[vecs[v].dut]), 32'd0);
      check($sformatf("vec%0d_err", v), 32'(err_v[vecs[v].dut]), 32'd0);
    end

    // Mode-0 master against the mode-1 slave must not deliver the word intact.
    c0 = rdy_cnt[1];
    spi_xfer(0, 64'hC3, 8, rx);
    check("wrongmode_rdy", 32'(rdy_cnt[1] - c0), 32'd1);
    n_checks++;
    if (last_data[1] == 16'h00C3) begin
      n_err++;
      $display("FAIL wrongmode_data: got %0h required not c3", last_data[1]);
    end

    // Reset mid-frame with cs held low: stays idle until a fresh cs fall.
    sck = 1'b0;
    clks(6);
    cs = 1'b0;
    clks(8);
    for (int b = 0; b < 4; b++) begin
      sck = 1'b1; mosi = 1'b1; clks(HALF);
      sck = 1'b0; clks(HALF);
    end
    reset = 1'b1;
    clks(3);
    reset = 1'b0;
    c0 = rdy_cnt[1];
    clks(6);
    check("midreset_data", 32'(dat8_v[1]), 32'd0);
    check("midreset_busy", 32'(busy_v[1]), 32'd0);
    for (int b = 0; b < 8; b++) begin
      sck = 1'b1; mosi = b[0]; clks(HALF);
      sck = 1'b0; clks(HALF);
    end
    clks(6);
    check("midreset_no_rdy", 32'(rdy_cnt[1] - c0), 32'd0);
    check("midreset_still_idle", 32'(busy_v[1]), 32'd0);
    mosi = 1'b0;
    cs = 1'b1;
    clks(8);
    c0 = rdy_cnt[1];
    spi_xfer(1, 64'h5A, 8, rx);
    check("postreset_rdy", 32'(rdy_cnt[1] - c0), 32'd1);
    check("postreset_data", 32'(last_data[1]), 32'h5A);
    check("postreset_idx", 32'(last_idx[1]), 32'd0);

`ifdef SPI_SLAVE_MISO_EN
    c0 = rdy_cnt[1];
    spi_xfer(1, 64'h00, 8, rx);
    check("miso_rx", 32'(rx[7:0]), 32'hA5);
    check("miso_slave_data", 32'(last_data[1]), 32'h00);
    check("miso_rdy", 32'(rdy_cnt[1] - c0), 32'd1);
    check("miso_idle", 32'(miso_v[1]), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
